gate_array_pipe: RTL



---
 rtl/gate_array_pipe_pkg.sv | 22 ++
 rtl/gate_array_stage.sv | 29 ++
 rtl/gate_array_pipe.sv | 92 +++++++++
 3 files changed

// File: rtl/gate_array_pipe_pkg.sv
// gate_array_pipe_pkg: gate mode codes, legal parameter limits and the stats counter width.
// Shared by the gate array top, its pipeline stage and the bench.
package gate_array_pipe_pkg;

  typedef enum logic [2:0] {
    GA_NAND = 3'd0,
    GA_AND  = 3'd1,
    GA_OR   = 3'd2,
    GA_NOR  = 3'd3,
    GA_XOR  = 3'd4,
    GA_XNOR = 3'd5,
    GA_BUF  = 3'd6,
    GA_INV  = 3'd7
  } ga_mode_e;

  localparam int GA_WIDTH_MIN  = 1;
  localparam int GA_WIDTH_MAX  = 64;
  localparam int GA_DELAY_MIN  = 1;
  localparam int GA_DELAY_MAX  = 16;
  localparam int GA_XFER_CNT_W = 16;

endpackage

// File: rtl/gate_array_stage.sv
// gate_array_stage: one {valid,data} elastic register of the gate array pipeline.
// Latency 1 cycle; up_rdy = !dn_vld || dn_rdy, so an empty stage fills even when downstream stalls.
// Data holds while dn_vld && !dn_rdy.
module gate_array_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             up_vld,
  output logic             up_rdy,
  input  logic [WIDTH-1:0] up_dat,
  output logic             dn_vld,
  input  logic             dn_rdy,
  output logic [WIDTH-1:0] dn_dat
);

  assign up_rdy = !dn_vld || dn_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dn_vld <= 1'b0;
      dn_dat <= '0;
    end else if (up_rdy) begin
      dn_vld <= up_vld;
      if (up_vld) dn_dat <= up_dat;
    end
  end

endmodule

// File: rtl/gate_array_pipe.sv
// gate_array_pipe: WIDTH-lane gate array (mode-selected) feeding a DELAY-stage elastic pipeline.
// Latency DELAY cycles, one beat per cycle; in_ready drops only when all DELAY stages are full and stalled.
// GATE_ARRAY_STATS_EN adds xfer_cnt, a saturating 16-bit count of output transfers.
module gate_array_pipe
  import gate_array_pipe_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DELAY = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       mode,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out1
`ifdef GATE_ARRAY_STATS_EN
  ,
  output logic [GA_XFER_CNT_W-1:0] xfer_cnt
`endif
);

  logic [WIDTH-1:0] gate_dat;

  // The mode is folded into the data here, so each beat carries its own function result.
  always_comb begin
    gate_dat = '0;
    case (mode)
      GA_NAND: gate_dat = ~(in1 & in2);
      GA_AND:  gate_dat = in1 & in2;
      GA_OR:   gate_dat = in1 | in2;
      GA_NOR:  gate_dat = ~(in1 | in2);
      GA_XOR:  gate_dat = in1 ^ in2;
      GA_XNOR: gate_dat = ~(in1 ^ in2);
      GA_BUF:  gate_dat = in1;
      GA_INV:  gate_dat = ~in1;
      default: gate_dat = '0;
    endcase
  end

  for (genvar k = 0; k < DELAY; k++) begin : g_stage
    logic             s_in_vld;
    logic             s_in_rdy;
    logic [WIDTH-1:0] s_in_dat;
    logic             s_out_vld;
    logic             s_dn_rdy;
    logic [WIDTH-1:0] s_out_dat;

    if (k == 0) begin : g_head
      assign s_in_vld = in_valid;
      assign s_in_dat = gate_dat;
    end else begin : g_link
      assign s_in_vld = g_stage[k-1].s_out_vld;
      assign s_in_dat = g_stage[k-1].s_out_dat;
    end

    if (k == DELAY - 1) begin : g_tail
      assign s_dn_rdy = out_ready;
    end else begin : g_next
      assign s_dn_rdy = g_stage[k+1].s_in_rdy;
    end

    gate_array_stage #(.WIDTH(WIDTH)) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .up_vld (s_in_vld),
      .up_rdy (s_in_rdy),
      .up_dat (s_in_dat),
      .dn_vld (s_out_vld),
      .dn_rdy (s_dn_rdy),
      .dn_dat (s_out_dat)
    );
  end

  assign in_ready  = g_stage[0].s_in_rdy;
  assign out_valid = g_stage[DELAY-1].s_out_vld;
  assign out1      = g_stage[DELAY-1].s_out_dat;

`ifdef GATE_ARRAY_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_cnt <= '0;
    end else if (out_valid && out_ready && (xfer_cnt != {GA_XFER_CNT_W{1'b1}})) begin
      xfer_cnt <= xfer_cnt + 1'b1;
    end
  end
`endif

endmodule
